// File: rtl/swervolf_mem_arb.sv
// Two-master AXI4 arbiter in front of the shared DDR2 memory port.
// Read and write directions each run an IDLE/GNT0/GNT1 FSM with a
// round-robin prio bit and allow one outstanding transaction.
// Ports: clk, rst (sync, active high), i_init_done gates new grants;
// i_m0_*/o_m0_* and i_m1_*/o_m1_* are the master AXI ports;
// o_s_*/i_s_* form the muxed AXI port toward the CDC/memory.
module swervolf_mem_arb #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_init_done,
  // master 0
  input  logic [ID_WIDTH-1:0]     i_m0_awid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_awaddr,
  input  logic [7:0]              i_m0_awlen,
  input  logic [2:0]              i_m0_awsize,
  input  logic [1:0]              i_m0_awburst,
  input  logic                    i_m0_awvalid,
  output logic                    o_m0_awready,
  input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_m0_wstrb,
  input  logic                    i_m0_wlast,
  input  logic                    i_m0_wvalid,
  output logic                    o_m0_wready,
  output logic [ID_WIDTH-1:0]     o_m0_bid,
  output logic [1:0]              o_m0_bresp,
  output logic                    o_m0_bvalid,
  input  logic                    i_m0_bready,
  input  logic [ID_WIDTH-1:0]     i_m0_arid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_araddr,
  input  logic [7:0]              i_m0_arlen,
  input  logic [2:0]              i_m0_arsize,
  input  logic [1:0]              i_m0_arburst,
  input  logic                    i_m0_arvalid,
  output logic                    o_m0_arready,
  output logic [ID_WIDTH-1:0]     o_m0_rid,
  output logic [DATA_WIDTH-1:0]   o_m0_rdata,
  output logic [1:0]              o_m0_rresp,
  output logic                    o_m0_rlast,
  output logic                    o_m0_rvalid,
  input  logic                    i_m0_rready,
  // master 1
  input  logic [ID_WIDTH-1:0]     i_m1_awid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_awaddr,
  input  logic [7:0]              i_m1_awlen,
  input  logic [2:0]              i_m1_awsize,
  input  logic [1:0]              i_m1_awburst,
  input  logic                    i_m1_awvalid,
  output logic                    o_m1_awready,
  input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_m1_wstrb,
  input  logic                    i_m1_wlast,
  input  logic                    i_m1_wvalid,
  output logic                    o_m1_wready,
  output logic [ID_WIDTH-1:0]     o_m1_bid,
  output logic [1:0]              o_m1_bresp,
  output logic                    o_m1_bvalid,
  input  logic                    i_m1_bready,
  input  logic [ID_WIDTH-1:0]     i_m1_arid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_araddr,
  input  logic [7:0]              i_m1_arlen,
  input  logic [2:0]              i_m1_arsize,
  input  logic [1:0]              i_m1_arburst,
  input  logic                    i_m1_arvalid,
  output logic                    o_m1_arready,
  output logic [ID_WIDTH-1:0]     o_m1_rid,
  output logic [DATA_WIDTH-1:0]   o_m1_rdata,
  output logic [1:0]              o_m1_rresp,
  output logic                    o_m1_rlast,
  output logic                    o_m1_rvalid,
  input  logic                    i_m1_rready,
  // memory side
  output logic [ID_WIDTH-1:0]     o_s_awid,
  output logic [ADDR_WIDTH-1:0]   o_s_awaddr,
  output logic [7:0]              o_s_awlen,
  output logic [2:0]              o_s_awsize,
  output logic [1:0]              o_s_awburst,
  output logic                    o_s_awvalid,
  input  logic                    i_s_awready,
  output logic [DATA_WIDTH-1:0]   o_s_wdata,
  output logic [DATA_WIDTH/8-1:0] o_s_wstrb,
  output logic                    o_s_wlast,
  output logic                    o_s_wvalid,
  input  logic                    i_s_wready,
  input  logic [ID_WIDTH-1:0]     i_s_bid,
  input  logic [1:0]              i_s_bresp,
  input  logic                    i_s_bvalid,
  output logic                    o_s_bready,
  output logic [ID_WIDTH-1:0]     o_s_arid,
  output logic [ADDR_WIDTH-1:0]   o_s_araddr,
  output logic [7:0]              o_s_arlen,
  output logic [2:0]              o_s_arsize,
  output logic [1:0]              o_s_arburst,
  output logic                    o_s_arvalid,
  input  logic                    i_s_arready,
  input  logic [ID_WIDTH-1:0]     i_s_rid,
  input  logic [DATA_WIDTH-1:0]   i_s_rdata,
  input  logic [1:0]              i_s_rresp,
  input  logic                    i_s_rlast,
  input  logic                    i_s_rvalid,
  output logic                    o_s_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } st_t;

  st_t  rd_st;
  st_t  wr_st;
  logic rd_prio;
  logic wr_prio;
  logic ar_done;
  logic aw_done;

  logic rd_g0;
  logic rd_g1;
  logic wr_g0;
  logic wr_g1;
  logic rd_win;
  logic wr_win;
  logic r_end;
  logic b_end;

  assign rd_g0 = (rd_st == GNT0);
  assign rd_g1 = (rd_st == GNT1);
  assign wr_g0 = (wr_st == GNT0);
  assign wr_g1 = (wr_st == GNT1);

  // prio only matters when both masters request
  assign rd_win = (i_m0_arvalid & i_m1_arvalid)
                ? rd_prio : i_m1_arvalid;
  assign wr_win = (i_m0_awvalid & i_m1_awvalid)
                ? wr_prio : i_m1_awvalid;

  assign r_end = i_s_rvalid & o_s_rready & i_s_rlast;
  assign b_end = i_s_bvalid & o_s_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st   <= IDLE;
      rd_prio <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      unique case (rd_st)
        IDLE: begin
          ar_done <= 1'b0;
          if (i_init_done &
              (i_m0_arvalid | i_m1_arvalid))
            rd_st <= rd_win ? GNT1 : GNT0;
        end
        GNT0, GNT1: begin
          if (o_s_arvalid & i_s_arready)
            ar_done <= 1'b1;
          if (r_end) begin
            rd_st   <= IDLE;
            rd_prio <= rd_g0;
          end
        end
        default: rd_st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st   <= IDLE;
      wr_prio <= 1'b0;
      aw_done <= 1'b0;
    end else begin
      unique case (wr_st)
        IDLE: begin
          aw_done <= 1'b0;
          if (i_init_done &
              (i_m0_awvalid | i_m1_awvalid))
            wr_st <= wr_win ? GNT1 : GNT0;
        end
        GNT0, GNT1: begin
          if (o_s_awvalid & i_s_awready)
            aw_done <= 1'b1;
          if (b_end) begin
            wr_st   <= IDLE;
            wr_prio <= wr_g0;
          end
        end
        default: wr_st <= IDLE;
      endcase
    end
  end

  // read address
  assign o_s_arid    = rd_g1 ? i_m1_arid    : i_m0_arid;
  assign o_s_araddr  = rd_g1 ? i_m1_araddr  : i_m0_araddr;
  assign o_s_arlen   = rd_g1 ? i_m1_arlen   : i_m0_arlen;
  assign o_s_arsize  = rd_g1 ? i_m1_arsize  : i_m0_arsize;
  assign o_s_arburst = rd_g1 ? i_m1_arburst : i_m0_arburst;
  assign o_s_arvalid = ~ar_done &
                       ((rd_g0 & i_m0_arvalid) |
                        (rd_g1 & i_m1_arvalid));
  assign o_m0_arready = rd_g0 & ~ar_done & i_s_arready;
  assign o_m1_arready = rd_g1 & ~ar_done & i_s_arready;

  // read data
  assign o_m0_rid    = i_s_rid;
  assign o_m0_rdata  = i_s_rdata;
  assign o_m0_rresp  = i_s_rresp;
  assign o_m0_rlast  = i_s_rlast;
  assign o_m0_rvalid = rd_g0 & i_s_rvalid;
  assign o_m1_rid    = i_s_rid;
  assign o_m1_rdata  = i_s_rdata;
  assign o_m1_rresp  = i_s_rresp;
  assign o_m1_rlast  = i_s_rlast;
  assign o_m1_rvalid = rd_g1 & i_s_rvalid;
  assign o_s_rready  = (rd_g0 & i_m0_rready) |
                       (rd_g1 & i_m1_rready);

  // write address
  assign o_s_awid    = wr_g1 ? i_m1_awid    : i_m0_awid;
  assign o_s_awaddr  = wr_g1 ? i_m1_awaddr  : i_m0_awaddr;
  assign o_s_awlen   = wr_g1 ? i_m1_awlen   : i_m0_awlen;
  assign o_s_awsize  = wr_g1 ? i_m1_awsize  : i_m0_awsize;
  assign o_s_awburst = wr_g1 ? i_m1_awburst : i_m0_awburst;
  assign o_s_awvalid = ~aw_done &
                       ((wr_g0 & i_m0_awvalid) |
                        (wr_g1 & i_m1_awvalid));
  assign o_m0_awready = wr_g0 & ~aw_done & i_s_awready;
  assign o_m1_awready = wr_g1 & ~aw_done & i_s_awready;

  // write data flows from grant entry, independent of AW
  assign o_s_wdata  = wr_g1 ? i_m1_wdata : i_m0_wdata;
  assign o_s_wstrb  = wr_g1 ? i_m1_wstrb : i_m0_wstrb;
  assign o_s_wlast  = wr_g1 ? i_m1_wlast : i_m0_wlast;
  assign o_s_wvalid = (wr_g0 & i_m0_wvalid) |
                      (wr_g1 & i_m1_wvalid);
  assign o_m0_wready = wr_g0 & i_s_wready;
  assign o_m1_wready = wr_g1 & i_s_wready;

  // write response
  assign o_m0_bid    = i_s_bid;
  assign o_m0_bresp  = i_s_bresp;
  assign o_m0_bvalid = wr_g0 & i_s_bvalid;
  assign o_m1_bid    = i_s_bid;
  assign o_m1_bresp  = i_s_bresp;
  assign o_m1_bvalid = wr_g1 & i_s_bvalid;
  assign o_s_bready  = (wr_g0 & i_m0_bready) |
                       (wr_g1 & i_m1_bready);

endmodule

// File: doc/swervolf_mem_arb.md
# swervolf_mem_arb

Two-master AXI4 arbiter sharing the single DDR2 memory port (the 32-bit address, 64-bit data, 6-bit ID AXI bus into the clock-domain crossing and LiteDRAM controller) between the CPU master (m0) and a second master (m1, e.g. DMA or debug loader). Read and write directions are arbitrated independently with round-robin fairness. Each direction allows exactly one outstanding transaction. No grant is issued until the memory reports init done. The block sits in the core clock domain, between the masters and the CDC.

## Interface
Parameters:
- ID_WIDTH, 6, AXI ID width (passed through unchanged).
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8.

Ports (mN = m0 and m1, each with an identical set; s = slave/memory side; directions given from the arbiter's view):
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_init_done  in  1  memory init complete; grants are blocked while 0.
- i_mN_aw{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  write address from master N.
- o_mN_awready  out  1  write address ready to master N.
- i_mN_w{data,strb,last,valid}  in  DATA/DATA/8/1/1  write data from master N.
- o_mN_wready  out  1  write data ready to master N.
- o_mN_b{id,resp,valid}  out  ID/2/1  write response to master N.
- i_mN_bready  in  1  write response ready from master N.
- i_mN_ar{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  read address from master N.
- o_mN_arready  out  1  read address ready to master N.
- o_mN_r{id,data,resp,last,valid}  out  ID/DATA/2/1/1  read data to master N.
- i_mN_rready  in  1  read data ready from master N.
- o_s_aw*/w*/ar*, o_s_bready, o_s_rready  out  same widths  muxed master-to-memory signals.
- i_s_awready, i_s_wready, i_s_arready, i_s_b*, i_s_r*  in  same widths  memory-to-master signals.

## Operation
- Each direction runs its own FSM: IDLE, GNT0, GNT1. Each direction also keeps a 1-bit priority register, prio (0 means m0 is preferred).
- Read FSM, IDLE: if i_init_done=1 and any mN_arvalid=1, pick a winner. If only one master requests, it wins. If both request, the master indicated by prio wins. Go to GNTn on the next edge.
- Read FSM, GNTn: forward mN ar* to o_s_ar*. Drive o_mN_arready = i_s_arready only until the first AR handshake. After that handshake, o_s_arvalid is forced to 0.
- Read FSM, GNTn (data): route i_s_r* to mN, with o_s_rready = i_mN_rready.
- Read FSM, exit: on an R handshake with rlast=1, return to IDLE and set prio to the other master.
- Write FSM: same structure, using awvalid as the request.
  - In GNTn, W is forwarded from mN from grant entry; W may precede or follow AW.
  - AW is forwarded until its handshake, then o_s_awvalid is forced to 0.
  - The exit condition is the B handshake (bvalid & bready), not wlast.
- The non-granted master always sees arready, awready and wready = 0, and rvalid and bvalid = 0.
- Data, ID, resp and len are passed through unmodified; no width conversion is performed.
- When a direction is in IDLE, all o_s_* valid/ready outputs for that direction are 0 and its data outputs are don't-care (driven from m0).
- i_init_done falling mid-transaction does not abort the transaction. It only blocks new grants from IDLE.

## Timing
- Reset: both FSMs go to IDLE and both prio registers to 0. All valid/ready outputs are 0 in the cycle after rst is sampled high.
- rst asserted mid-transaction abandons the transaction immediately. The masters and memory are reset by the same rst.
- Grant latency: a request visible at edge k gives o_s_arvalid/o_s_awvalid = 1 in cycle k+1. Minimum IDLE dwell is 1 cycle between transactions.
- Each direction's master-to-slave path is combinational once granted; there is no added pipeline stage.
- Read and write may be granted to different masters in the same cycle.
- Simultaneous requests in IDLE are resolved by prio only. A master that keeps its request asserted gets at worst every second grant.
- Requests must hold valid until handshake (AXI rule); the arbiter does not latch requests.

## Test plan
- Reset, then i_init_done=0 with m0 and m1 arvalid=1 for 20 cycles: no o_s_arvalid, both arready=0. Then raise i_init_done: o_s_arvalid=1 exactly one cycle later, with m0's address.
- m0 read, len=3 (4 beats), with memory rready throttled every other cycle: m0 receives 4 beats with correct data and rlast on beat 4. m1 sees rvalid=0 throughout. FSM returns to IDLE one cycle after the rlast handshake.
- m0 and m1 issue reads back-to-back continuously: grants alternate m0, m1, m0, m1 over 8 transactions, and addresses reach the memory in that order.
- m1 write with W valid 2 cycles before AW, len=1: both W beats are forwarded only after the grant. bid equals m1's awid, and B is delivered to m1 only. The write grant is released on the B handshake, not on wlast.
- Concurrent m0 write and m1 read: both are granted in the same cycle and complete independently with correct routing.
- rst asserted on the 2nd R beat of a 4-beat read: the next cycle has all valid/ready outputs at 0, the FSM in IDLE and prio at 0.
